fetch_thread_scheduler: RTL and testbench
=========================================

Name: fetch_thread_scheduler

Overview:
- Front of the fetch stage for the fine-grained multithreaded core.
- Holds one PC per hardware thread and picks one ready thread per cycle, round-robin.
- Presents the chosen PC and thread_id to the I-cache and the fetch/decode pipeline register.
- Parks a thread on I-cache miss until its refill completes; applies per-thread branch redirects from decode-stage branch resolution.

Parameters:
- NUM_THREADS, 4, number of hardware threads (power of two, ≥2).
- ADDR_WIDTH, 16, PC width in bits; matches core `ADDR_WIDTH`.
- TID_WIDTH, $clog2(NUM_THREADS), thread_id width.
- RESET_PC, 0, reset PC of thread 0.
- THREAD_PC_STRIDE, 'h1000, reset PC spacing between threads.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- i_thread_enable  in  NUM_THREADS  per-thread run enable; a 0 bit means the thread is never selected.
- i_stall  in  1  hazard-controller stall of fetch.
- i_icache_miss  in  1  the currently presented fetch missed; only meaningful when o_fetch_valid=1 and i_stall=0.
- i_refill_done  in  1  I-cache refill finished.
- i_refill_thread_id  in  TID_WIDTH  thread whose refill finished.
- i_redirect_valid  in  1  branch/jump resolved taken in decode.
- i_redirect_thread_id  in  TID_WIDTH  thread being redirected.
- i_redirect_target  in  ADDR_WIDTH  new PC for that thread.
- o_fetch_valid  out  1  fetch request valid.
- o_fetch_pc  out  ADDR_WIDTH  PC of the selected thread.
- o_fetch_thread_id  out  TID_WIDTH  selected thread.
- o_parked_mask  out  NUM_THREADS  threads waiting on a refill.

Behaviour:
State:
- pc_q[t]
- parked_q[t]
- sel_q (TID_WIDTH)
- valid_q

Reset (async, rst_n=0):
- pc_q[t] = RESET_PC + t*THREAD_PC_STRIDE (truncated to ADDR_WIDTH).
- parked_q = 0; sel_q = 0; valid_q = 0.
- Outputs during reset: o_fetch_valid=0, o_fetch_thread_id=0, o_fetch_pc=RESET_PC, o_parked_mask=0.

Outputs:
- o_fetch_valid = valid_q.
- o_fetch_thread_id = sel_q.
- o_fetch_pc = pc_q[sel_q], a combinational read of registered state.
- o_parked_mask = parked_q.
- No combinational path from any input to any output.

Per-cycle events:
- accept = valid_q & ~i_stall & ~i_icache_miss.
- miss = valid_q & ~i_stall & i_icache_miss.

Per-thread next state, highest priority first:
1. Redirect to t: pc_q[t] ← i_redirect_target; parked_q[t] ← 0. A wrong-path miss is discarded, and a same-cycle accept or miss for t does not change pc or park the thread.
2. miss and sel_q==t: parked_q[t] ← 1; pc_q[t] unchanged, so the same PC is refetched after refill.
3. accept and sel_q==t: pc_q[t] ← pc_q[t]+4, mod 2^ADDR_WIDTH (wrap-around, no flag).
4. i_refill_done and i_refill_thread_id==t and parked_q[t]: parked_q[t] ← 0. A refill for an unparked thread is ignored.

Selection:
- ready[t] = i_thread_enable[t] & ~parked_next[t].
- Selection updates when ~valid_q, or accept, or miss. During i_stall with valid_q=1, sel_q and valid_q hold.
- Redirects and refills still apply during stall, so o_fetch_pc may change under stall if sel_q is redirected.
- Search start is sel_q+1 (mod NUM_THREADS) when valid_q=1, else sel_q. The first ready thread from the start, wrapping, becomes sel_q. The current thread is eligible last.
- valid_q ← |ready. If no thread is ready, valid_q=0 and sel_q holds.

Latency:
- Redirect or refill is visible at the outputs the cycle after it is asserted.
- An accepted fetch advances to the next thread in 1 cycle.
- Single thread enabled: fetches back-to-back every cycle.

Illegal inputs, behaviour undefined, flagged by bench assertions:
- i_icache_miss with valid_q=0.
- i_redirect_thread_id ≥ NUM_THREADS.

Reset mid-operation: all state returns to reset values immediately; outstanding refills are forgotten.

Test Plan (NUM_THREADS=4, RESET_PC=0, stride 'h1000):
- Reset release, enable=4'hF, no stall/miss → cycle 1 valid=1 (t0,'h0000), then t1 'h1000, t2 'h2000, t3 'h3000, t0 'h0004.
- Miss on t1 'h1000 → parked_mask=4'b0010; rotation t2,t3,t0,t2…; refill_done tid=1 → t1 re-selected in rotation at 'h1000.
- i_stall=1 for 3 cycles while presenting t2 'h2000 → outputs hold t2/'h2000, no PC increment; release → t2 accepted, t3 next.
- Redirect tid=0 target 'h0400 in the same cycle t0 misses → t0 not parked, t0's next fetch PC='h0400.
- enable=4'b0001, pc_q[0]='hFFFC → fetches 'hFFFC then 'h0000 on consecutive cycles (wrap), valid stays 1.
- enable=0, or all enabled threads parked → valid=0; refill of a parked thread → valid=1 next cycle with that thread; rst_n pulse mid-run → all PCs back to reset values asynchronously.

Source files
------------

// File: rtl/fetch_thread_scheduler.sv
// Fetch-stage thread scheduler: holds one PC per hardware thread and picks one
// ready thread per cycle round-robin, parking threads that miss in the I-cache.
module fetch_thread_scheduler #(
    parameter int unsigned NUM_THREADS      = 4,
    parameter int unsigned ADDR_WIDTH       = 16,
    parameter int unsigned TID_WIDTH        = $clog2(NUM_THREADS),
    parameter int unsigned RESET_PC         = 0,
    parameter int unsigned THREAD_PC_STRIDE = 'h1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_THREADS-1:0] i_thread_enable,
    input  logic                   i_stall,
    input  logic                   i_icache_miss,
    input  logic                   i_refill_done,
    input  logic [TID_WIDTH-1:0]   i_refill_thread_id,
    input  logic                   i_redirect_valid,
    input  logic [TID_WIDTH-1:0]   i_redirect_thread_id,
    input  logic [ADDR_WIDTH-1:0]  i_redirect_target,
    output logic                   o_fetch_valid,
    output logic [ADDR_WIDTH-1:0]  o_fetch_pc,
    output logic [TID_WIDTH-1:0]   o_fetch_thread_id,
    output logic [NUM_THREADS-1:0] o_parked_mask
);

    function automatic logic [ADDR_WIDTH-1:0] reset_pc(input int unsigned t);
        logic [63:0] full;
        full = 64'(RESET_PC) + 64'(t) * 64'(THREAD_PC_STRIDE);
        return full[ADDR_WIDTH-1:0];
    endfunction

    logic [ADDR_WIDTH-1:0]  pc_q [NUM_THREADS];
    logic [ADDR_WIDTH-1:0]  pc_d [NUM_THREADS];
    logic [NUM_THREADS-1:0] parked_q, parked_d;
    logic [TID_WIDTH-1:0]   sel_q, sel_d;
    logic                   valid_q, valid_d;

    logic                   accept, miss, update_sel, found;
    logic [NUM_THREADS-1:0] ready;
    logic [TID_WIDTH-1:0]   start, cand;

    always_comb begin
        accept = valid_q & ~i_stall & ~i_icache_miss;
        miss   = valid_q & ~i_stall &  i_icache_miss;

        // A redirect wins over everything for its thread, including a wrong-path miss.
        for (int t = 0; t < NUM_THREADS; t++) begin
            pc_d[t]     = pc_q[t];
            parked_d[t] = parked_q[t];
            if (i_redirect_valid && (i_redirect_thread_id == TID_WIDTH'(t))) begin
                pc_d[t]     = i_redirect_target;
                parked_d[t] = 1'b0;
            end else if (miss && (sel_q == TID_WIDTH'(t))) begin
                parked_d[t] = 1'b1;
            end else if (accept && (sel_q == TID_WIDTH'(t))) begin
                pc_d[t] = pc_q[t] + ADDR_WIDTH'(4);
            end else if (i_refill_done && (i_refill_thread_id == TID_WIDTH'(t)) && parked_q[t]) begin
                parked_d[t] = 1'b0;
            end
        end
    end

    always_comb begin
        ready      = i_thread_enable & ~parked_d;
        update_sel = ~valid_q | accept | miss;
        start      = valid_q ? sel_q + 1'b1 : sel_q;
        cand       = start;
        found      = 1'b0;
        sel_d      = sel_q;
        valid_d    = valid_q;

        // Current thread is reached last when the search starts one past it.
        if (update_sel) begin
            valid_d = |ready;
            for (int i = 0; i < NUM_THREADS; i++) begin
                cand = start + TID_WIDTH'(i);
                if (!found && ready[cand]) begin
                    found = 1'b1;
                    sel_d = cand;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc_q[t] <= reset_pc(t);
            end
            parked_q <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc_q[t] <= pc_d[t];
            end
            parked_q <= parked_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
        end
    end

    assign o_fetch_valid     = valid_q;
    assign o_fetch_thread_id = sel_q;
    assign o_fetch_pc        = pc_q[sel_q];
    assign o_parked_mask     = parked_q;

endmodule

// File: tb/tb_fetch_thread_scheduler.sv
// Bench for fetch_thread_scheduler: directed scenarios with fixed expectations
// plus a randomized run against a behavioural reference model.
module tb_fetch_thread_scheduler;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  en;
    logic          stall, miss, refill, redir;
    logic [TW-1:0] refill_tid, redir_tid;
    logic [AW-1:0] redir_tgt;
    logic          fv;
    logic [AW-1:0] fpc;
    logic [TW-1:0] ftid;
    logic [N-1:0]  pmask;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_thread_scheduler #(
        .NUM_THREADS(N), .ADDR_WIDTH(AW), .TID_WIDTH(TW),
        .RESET_PC(0), .THREAD_PC_STRIDE('h1000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_thread_enable(en), .i_stall(stall),
        .i_icache_miss(miss), .i_refill_done(refill), .i_refill_thread_id(refill_tid),
        .i_redirect_valid(redir), .i_redirect_thread_id(redir_tid),
        .i_redirect_target(redir_tgt), .o_fetch_valid(fv), .o_fetch_pc(fpc),
        .o_fetch_thread_id(ftid), .o_parked_mask(pmask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) assert (!(miss && !fv)) else $error("illegal stimulus: miss while not valid");
    end

    // Reference model: per-thread PCs, parked set, current pick.
    logic [AW-1:0] m_pc [N];
    logic [N-1:0]  m_parked;
    logic [TW-1:0] m_sel;
    logic          m_valid;

    task automatic model_reset();
        for (int t = 0; t < N; t++) m_pc[t] = AW'(t * 'h1000);
        m_parked = '0;
        m_sel    = '0;
        m_valid  = 1'b0;
    endtask

    task automatic model_step();
        logic [AW-1:0] npc [N];
        logic [N-1:0]  npk;
        bit acc, ms, found;
        int cur, first, c;
        cur = int'(m_sel);
        acc = m_valid && !stall && !miss;
        ms  = m_valid && !stall && miss;
        for (int t = 0; t < N; t++) begin
            npc[t] = m_pc[t];
            npk[t] = m_parked[t];
        end
        for (int t = 0; t < N; t++) begin
            if (redir && int'(redir_tid) == t) begin
                npc[t] = redir_tgt;
                npk[t] = 1'b0;
            end else if (ms && cur == t) npk[t] = 1'b1;
            else if (acc && cur == t) npc[t] = AW'((int'(m_pc[t]) + 4) % 65536);
            else if (refill && int'(refill_tid) == t && m_parked[t]) npk[t] = 1'b0;
        end
        if (!m_valid || acc || ms) begin
            first = m_valid ? (cur + 1) % N : cur;
            found = 0;
            for (int k = 0; k < N; k++) begin
                c = (first + k) % N;
                if (!found && en[c] && !npk[c]) begin
                    found = 1;
                    cur   = c;
                end
            end
            m_valid = found;
            m_sel   = TW'(cur);
        end
        for (int t = 0; t < N; t++) m_pc[t] = npc[t];
        m_parked = npk;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; miss = 0; refill = 0; refill_tid = '0;
        redir = 0; redir_tid = '0; redir_tgt = '0;
    endtask

    task automatic do_reset(input logic [N-1:0] enable);
        idle_inputs();
        en    = enable;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        en    = 4'hF;
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        n_tests++;
        if (fv !== 1'b0 || ftid !== 2'd0 || fpc !== 16'h0000 || pmask !== 4'h0) begin
            n_fail++;
            $display("FAIL reset: got v=%0b tid=%0d pc=%h mask=%b, want v=0 tid=0 pc=0000 mask=0000",
                     fv, ftid, fpc, pmask);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [TW-1:0] et [5];
        logic [AW-1:0] ep [5];
        et = '{0, 1, 2, 3, 0};
        ep = '{16'h0000, 16'h1000, 16'h2000, 16'h3000, 16'h0004};
        do_reset(4'hF);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (fv !== 1'b1 || ftid !== et[i] || fpc !== ep[i]) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: got v=%0b tid=%0d pc=%h, want v=1 tid=%0d pc=%h",
                         i, fv, ftid, fpc, et[i], ep[i]);
            end
        end
    endtask

    task automatic test_miss_refill();
        logic [TW-1:0] et [9];
        logic [AW-1:0] ep [9];
        logic [N-1:0]  em [9];
        et = '{0, 1, 2, 3, 0, 2, 3, 0, 1};
        ep = '{16'h0000, 16'h1000, 16'h2000, 16'h3000, 16'h0004,
               16'h2004, 16'h3004, 16'h0008, 16'h1000};
        em = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0};
        do_reset(4'hF);
        for (int i = 0; i < 9; i++) begin
            miss       = (i == 2);
            refill     = (i == 6);
            refill_tid = 2'd1;
            tick();
            n_tests++;
            if (fv !== 1'b1 || ftid !== et[i] || fpc !== ep[i] || pmask !== em[i]) begin
                n_fail++;
                $display("FAIL miss_refill[%0d]: got v=%0b tid=%0d pc=%h mask=%b, want v=1 tid=%0d pc=%h mask=%b",
                         i, fv, ftid, fpc, pmask, et[i], ep[i], em[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        logic [TW-1:0] et [10];
        logic [AW-1:0] ep [10];
        et = '{0, 1, 2, 2, 2, 2, 3, 0, 1, 2};
        ep = '{16'h0000, 16'h1000, 16'h2000, 16'h2000, 16'h2000, 16'h2000,
               16'h3000, 16'h0004, 16'h1004, 16'h2004};
        do_reset(4'hF);
        for (int i = 0; i < 10; i++) begin
            stall = (i >= 3 && i <= 5);
            tick();
            n_tests++;
            if (fv !== 1'b1 || ftid !== et[i] || fpc !== ep[i]) begin
                n_fail++;
                $display("FAIL stall[%0d]: got v=%0b tid=%0d pc=%h, want v=1 tid=%0d pc=%h",
                         i, fv, ftid, fpc, et[i], ep[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_redirect_over_miss();
        logic [TW-1:0] et [5];
        logic [AW-1:0] ep [5];
        et = '{0, 1, 2, 3, 0};
        ep = '{16'h0000, 16'h1000, 16'h2000, 16'h3000, 16'h0400};
        do_reset(4'hF);
        for (int i = 0; i < 5; i++) begin
            miss      = (i == 1);
            redir     = (i == 1);
            redir_tid = 2'd0;
            redir_tgt = 16'h0400;
            tick();
            n_tests++;
            if (fv !== 1'b1 || ftid !== et[i] || fpc !== ep[i] || pmask !== 4'h0) begin
                n_fail++;
                $display("FAIL redirect_miss[%0d]: got v=%0b tid=%0d pc=%h mask=%b, want v=1 tid=%0d pc=%h mask=0000",
                         i, fv, ftid, fpc, pmask, et[i], ep[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back_wrap();
        logic [AW-1:0] ep [4];
        ep = '{16'h0000, 16'hFFFC, 16'h0000, 16'h0004};
        do_reset(4'b0001);
        for (int i = 0; i < 4; i++) begin
            redir     = (i == 1);
            redir_tid = 2'd0;
            redir_tgt = 16'hFFFC;
            tick();
            n_tests++;
            if (fv !== 1'b1 || ftid !== 2'd0 || fpc !== ep[i]) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got v=%0b tid=%0d pc=%h, want v=1 tid=0 pc=%h",
                         i, fv, ftid, fpc, ep[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_idle_and_all_parked();
        logic          ev [5];
        logic [TW-1:0] et [5];
        logic [AW-1:0] ep [5];
        logic [N-1:0]  em [5];
        do_reset(4'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (fv !== 1'b0 || ftid !== 2'd0 || fpc !== 16'h0000) begin
                n_fail++;
                $display("FAIL no_enable[%0d]: got v=%0b tid=%0d pc=%h, want v=0 tid=0 pc=0000",
                         i, fv, ftid, fpc);
            end
        end
        ev = '{1, 1, 0, 0, 1};
        et = '{0, 1, 1, 1, 0};
        ep = '{16'h0000, 16'h1000, 16'h1000, 16'h1000, 16'h0000};
        em = '{4'h0, 4'h1, 4'h3, 4'h3, 4'h2};
        en = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            miss       = (i == 1 || i == 2);
            refill     = (i == 4);
            refill_tid = 2'd0;
            tick();
            n_tests++;
            if (fv !== ev[i] || ftid !== et[i] || fpc !== ep[i] || pmask !== em[i]) begin
                n_fail++;
                $display("FAIL all_parked[%0d]: got v=%0b tid=%0d pc=%h mask=%b, want v=%0b tid=%0d pc=%h mask=%b",
                         i, fv, ftid, fpc, pmask, ev[i], et[i], ep[i], em[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        logic [TW-1:0] et [3];
        logic [AW-1:0] ep [3];
        et = '{0, 1, 2};
        ep = '{16'h0000, 16'h1000, 16'h2000};
        do_reset(4'hF);
        for (int i = 0; i < 6; i++) begin
            miss = (i == 3);
            tick();
        end
        miss  = 0;
        rst_n = 1'b0;
        model_reset();
        #2;
        n_tests++;
        if (fv !== 1'b0 || ftid !== 2'd0 || fpc !== 16'h0000 || pmask !== 4'h0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%0b tid=%0d pc=%h mask=%b, want v=0 tid=0 pc=0000 mask=0000",
                     fv, ftid, fpc, pmask);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (fv !== 1'b1 || ftid !== et[i] || fpc !== ep[i] || pmask !== 4'h0) begin
                n_fail++;
                $display("FAIL after_reset[%0d]: got v=%0b tid=%0d pc=%h mask=%b, want v=1 tid=%0d pc=%h mask=0000",
                         i, fv, ftid, fpc, pmask, et[i], ep[i]);
            end
        end
    endtask

    task automatic test_random();
        do_reset(4'hF);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) en = N'($urandom);
            stall      = ($urandom_range(0, 3) == 0);
            miss       = fv && ($urandom_range(0, 4) == 0);
            refill     = ($urandom_range(0, 2) == 0);
            refill_tid = TW'($urandom);
            redir      = ($urandom_range(0, 6) == 0);
            redir_tid  = TW'($urandom);
            redir_tgt  = AW'($urandom) & 16'hFFFC;
            tick();
            n_tests++;
            if (fv !== m_valid || ftid !== m_sel || fpc !== m_pc[m_sel] || pmask !== m_parked) begin
                n_fail++;
                $display("FAIL random[%0d]: got v=%0b tid=%0d pc=%h mask=%b, want v=%0b tid=%0d pc=%h mask=%b",
                         i, fv, ftid, fpc, pmask, m_valid, m_sel, m_pc[m_sel], m_parked);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_miss_refill();
        test_stall();
        test_redirect_over_miss();
        test_back_to_back_wrap();
        test_idle_and_all_parked();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
